// File: rtl/core_inst_enc_pkg.sv
// Shared RV32I encoding constants: format codes, opcodes, funct fields, NOP
// and the request payload struct. Opcode/funct constants are also used by decode.
package core_inst_enc_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        ENC_FMT_R = 3'd0,
        ENC_FMT_I = 3'd1,
        ENC_FMT_S = 3'd2,
        ENC_FMT_B = 3'd3,
        ENC_FMT_U = 3'd4,
        ENC_FMT_J = 3'd5
    } enc_fmt_e;

    localparam logic [OPC_W-1:0] INST_TYPE_LOAD   = 7'h03;
    localparam logic [OPC_W-1:0] INST_TYPE_FENCE  = 7'h0F;
    localparam logic [OPC_W-1:0] INST_TYPE_OPIMM  = 7'h13;
    localparam logic [OPC_W-1:0] INST_TYPE_AUIPC  = 7'h17;
    localparam logic [OPC_W-1:0] INST_TYPE_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] INST_TYPE_OP     = 7'h33;
    localparam logic [OPC_W-1:0] INST_TYPE_LUI    = 7'h37;
    localparam logic [OPC_W-1:0] INST_TYPE_BRANCH = 7'h63;
    localparam logic [OPC_W-1:0] INST_TYPE_JALR   = 7'h67;
    localparam logic [OPC_W-1:0] INST_TYPE_JAL    = 7'h6F;
    localparam logic [OPC_W-1:0] INST_TYPE_SYSTEM = 7'h73;

    localparam logic [F3_W-1:0] INST_FUNC3_ADD  = 3'd0;
    localparam logic [F3_W-1:0] INST_FUNC3_SLL  = 3'd1;
    localparam logic [F3_W-1:0] INST_FUNC3_SLT  = 3'd2;
    localparam logic [F3_W-1:0] INST_FUNC3_SLTU = 3'd3;
    localparam logic [F3_W-1:0] INST_FUNC3_XOR  = 3'd4;
    localparam logic [F3_W-1:0] INST_FUNC3_SRL  = 3'd5;
    localparam logic [F3_W-1:0] INST_FUNC3_OR   = 3'd6;
    localparam logic [F3_W-1:0] INST_FUNC3_AND  = 3'd7;

    localparam logic [F7_W-1:0] INST_FUNC7_BASE = 7'h00;
    localparam logic [F7_W-1:0] INST_FUNC7_ALT  = 7'h20;

    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [FMT_W-1:0] fmt;
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  func3;
        logic [F7_W-1:0]  func7;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  imm;
    } enc_req_t;

    // True when imm is representable as a signed value of (msb+1) bits.
    function automatic logic imm_fits(input logic [XLEN-1:0] imm, input int unsigned msb);
        logic [XLEN-1:0] hi;
        hi = XLEN'($signed(imm) >>> msb);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/core_inst_enc_fifo.sv
// Two-entry 32-bit synchronous FIFO with flush; head is visible without a pop.
module core_inst_enc_fifo
    import core_inst_enc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_in,
    input  logic            push_in,
    input  logic [XLEN-1:0] data_in,
    input  logic            pop_in,
    output logic [XLEN-1:0] data_out,
    output logic            full_out,
    output logic            empty_out
);

    localparam int unsigned CNT_W = 2;

    logic [XLEN-1:0]  mem_q [2];
    logic [XLEN-1:0]  mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_push  = push_in && (cnt_q != CNT_W'(2));
        do_pop   = pop_in && (cnt_q != CNT_W'(0));
        if (flush_in) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_in;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign data_out  = mem_q[rd_ptr_q];
    assign full_out  = (cnt_q == CNT_W'(2));
    assign empty_out = (cnt_q == CNT_W'(0));

endmodule

// File: rtl/core_inst_enc.sv
// RV32I instruction encoder: packs decoded fields into words and streams them
// to instruction memory at a wrapping address. Build option: ENC_CHECK_EN.
module core_inst_enc
    import core_inst_enc_pkg::*;
#(
    parameter int unsigned     MEM_DEPTH = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_in,
    output logic             req_ready_out,
    input  logic [FMT_W-1:0] fmt_in,
    input  logic [OPC_W-1:0] opcode_in,
    input  logic [F3_W-1:0]  func3_in,
    input  logic [F7_W-1:0]  func7_in,
    input  logic [REG_W-1:0] rs1_in,
    input  logic [REG_W-1:0] rs2_in,
    input  logic [REG_W-1:0] rd_in,
    input  logic [XLEN-1:0]  imm_in,
    input  logic             flush_in,
    output logic             mem_we_out,
    output logic [XLEN-1:0]  mem_addr_out,
    output logic [XLEN-1:0]  mem_data_out,
    input  logic             mem_ready_in,
    output logic [XLEN-1:0]  inst_count_out,
    output logic             err_out
);

    localparam logic [XLEN-1:0] LAST_ADDR = BASE_ADDR + XLEN'(4 * (MEM_DEPTH - 1));

    enc_req_t        req;
    logic [XLEN-1:0] enc_word;
    logic            illegal;
    logic            accept;
    logic            write;
    logic            fifo_full, fifo_empty;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    always_comb begin
        req.fmt    = fmt_in;
        req.opcode = opcode_in;
        req.func3  = func3_in;
        req.func7  = func7_in;
        req.rs1    = rs1_in;
        req.rs2    = rs2_in;
        req.rd     = rd_in;
        req.imm    = imm_in;
    end

    // Field packing; anything outside the six formats becomes a NOP.
    always_comb begin
        enc_word = INST_NOP;
        case (req.fmt)
            ENC_FMT_R: enc_word = {req.func7, req.rs2, req.rs1, req.func3, req.rd, req.opcode};
            ENC_FMT_I: enc_word = {req.imm[11:0], req.rs1, req.func3, req.rd, req.opcode};
            ENC_FMT_S: enc_word = {req.imm[11:5], req.rs2, req.rs1, req.func3,
                                   req.imm[4:0], req.opcode};
            ENC_FMT_B: enc_word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.func3,
                                   req.imm[4:1], req.imm[11], req.opcode};
            ENC_FMT_U: enc_word = {req.imm[31:12], req.rd, req.opcode};
            ENC_FMT_J: enc_word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                                   req.rd, req.opcode};
            default:   enc_word = INST_NOP;
        endcase
    end

`ifdef ENC_CHECK_EN
    // Illegal field sets complete the handshake but are dropped.
    always_comb begin
        illegal = 1'b0;
        case (req.fmt)
            ENC_FMT_R:            illegal = 1'b0;
            ENC_FMT_I, ENC_FMT_S: illegal = !imm_fits(req.imm, 11);
            ENC_FMT_B:            illegal = !imm_fits(req.imm, 12) || req.imm[0];
            ENC_FMT_U:            illegal = (req.imm[11:0] != '0);
            ENC_FMT_J:            illegal = !imm_fits(req.imm, 20) || req.imm[0];
            default:              illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

    assign accept = req_valid_in && req_ready_out && !flush_in;
    assign write  = mem_we_out && mem_ready_in;

    core_inst_enc_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush_in  (flush_in),
        .push_in   (accept && !illegal),
        .data_in   (enc_word),
        .pop_in    (write),
        .data_out  (mem_data_out),
        .full_out  (fifo_full),
        .empty_out (fifo_empty)
    );

    // Address wraps over the memory window; count saturates.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        err_d  = accept && illegal;
        if (flush_in) begin
            addr_d = BASE_ADDR;
            cnt_d  = '0;
        end else if (write) begin
            addr_d = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + XLEN'(4);
            if (cnt_q != '1) begin
                cnt_d = cnt_q + XLEN'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= BASE_ADDR;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign req_ready_out  = !fifo_full;
    assign mem_we_out     = !fifo_empty;
    assign mem_addr_out   = addr_q;
    assign inst_count_out = cnt_q;
    assign err_out        = err_q;

endmodule

// File: tb/tb_core_inst_enc.sv
// Self-checking bench for core_inst_enc: directed vectors, multi-cycle corner
// sequences and randomized traffic against a queue-based reference model.
module tb_core_inst_enc;
    import core_inst_enc_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    logic [2:0]  fmt_in = '0;
    logic [6:0]  opcode_in = '0;
    logic [2:0]  func3_in = '0;
    logic [6:0]  func7_in = '0;
    logic [4:0]  rs1_in = '0, rs2_in = '0, rd_in = '0;
    logic [31:0] imm_in = '0;
    logic        flush_in = 1'b0;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic        mem_ready_in = 1'b0;
    logic [31:0] inst_count_out;
    logic        err_out;

    core_inst_enc #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .fmt_in(fmt_in), .opcode_in(opcode_in), .func3_in(func3_in), .func7_in(func7_in),
        .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .imm_in(imm_in),
        .flush_in(flush_in),
        .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .mem_ready_in(mem_ready_in),
        .inst_count_out(inst_count_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
    } req_t;

    typedef struct {
        string       name;
        req_t        r;
        logic [31:0] exp_word;
        logic [31:0] exp_addr;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          m_idx;
    logic [31:0] m_count;
    logic        m_err;
    int          writes = 0;
    logic [31:0] last_data, last_addr;
    bit          mon_en = 0;
    bit          mon_acc, mon_wr;
    req_t        mon_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm);
        req_t r;
        r.fmt = fmt; r.op = op; r.f3 = f3; r.f7 = f7;
        r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.imm = imm;
        return r;
    endfunction

    // Reference encoding: place each field with shifts and masks.
    function automatic logic [31:0] model_enc(input req_t r);
        logic [31:0] i, op, rd, rs1, rs2, f3, f7;
        i = r.imm; op = 32'(r.op); rd = 32'(r.rd) << 7; rs1 = 32'(r.rs1) << 15;
        rs2 = 32'(r.rs2) << 20; f3 = 32'(r.f3) << 12; f7 = 32'(r.f7) << 25;
        case (r.fmt)
            3'd0: return f7 | rs2 | rs1 | f3 | rd | op;
            3'd1: return ((i & 32'hFFF) << 20) | rs1 | f3 | rd | op;
            3'd2: return (((i >> 5) & 32'h7F) << 25) | rs2 | rs1 | f3 | ((i & 32'h1F) << 7) | op;
            3'd3: return (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3F) << 25) | rs2 | rs1 | f3
                         | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 1) << 7) | op;
            3'd4: return (i & 32'hFFFF_F000) | rd | op;
            3'd5: return (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3FF) << 21)
                         | (((i >> 11) & 1) << 20) | (((i >> 12) & 32'hFF) << 12) | rd | op;
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic bit model_legal(input req_t r);
`ifdef ENC_CHECK_EN
        int v;
        bit even;
        v = int'(r.imm);
        even = ((r.imm & 32'h1) == 0);
        case (r.fmt)
            3'd0: return 1'b1;
            3'd1, 3'd2: return (v >= -2048) && (v <= 2047);
            3'd3: return (v >= -4096) && (v <= 4094) && even;
            3'd4: return (r.imm & 32'hFFF) == 0;
            3'd5: return (v >= -(1 << 20)) && (v <= (1 << 20) - 2) && even;
            default: return 1'b0;
        endcase
`else
        return r.fmt == r.fmt;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_idx = 0;
        m_count = 0;
        m_err = 0;
    endtask

    // Scoreboard: update the model on each edge, then compare all outputs.
    always @(posedge clk) begin
        if (mon_en && rst) begin
            mon_acc = req_valid_in && req_ready_out && !flush_in;
            mon_wr  = mem_we_out && mem_ready_in;
            mon_r   = mk(fmt_in, opcode_in, func3_in, func7_in, rs1_in, rs2_in, rd_in, imm_in);
            m_err   = 0;
            if (flush_in) begin
                exp_q.delete();
                m_idx = 0;
                m_count = 0;
            end else begin
                if (mon_wr) begin
                    last_data = mem_data_out;
                    last_addr = mem_addr_out;
                    writes++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    m_idx = (m_idx + 1) % DEPTH;
                    if (m_count != 32'hFFFF_FFFF) m_count++;
                end
                if (mon_acc) begin
                    if (model_legal(mon_r)) exp_q.push_back(model_enc(mon_r));
                    else m_err = 1;
                end
            end
            #2;
            check("mon_we", 32'(mem_we_out), 32'(exp_q.size() > 0));
            check("mon_ready", 32'(req_ready_out), 32'(exp_q.size() < 2));
            check("mon_count", inst_count_out, m_count);
            check("mon_err", 32'(err_out), 32'(m_err));
            check("mon_addr", mem_addr_out, BASE + 32'(4 * m_idx));
            if (exp_q.size() > 0) check("mon_data", mem_data_out, exp_q[0]);
        end
    end

    task automatic drive(input req_t r);
        fmt_in = r.fmt; opcode_in = r.op; func3_in = r.f3; func7_in = r.f7;
        rs1_in = r.rs1; rs2_in = r.rs2; rd_in = r.rd; imm_in = r.imm;
    endtask

    task automatic send(input req_t r);
        int n;
        n = 0;
        drive(r);
        req_valid_in = 1'b1;
        while (!req_ready_out && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL send_timeout: ready stayed %0b, required 1", req_ready_out);
        end
        @(posedge clk); #1;
        req_valid_in = 1'b0;
    endtask

    task automatic wait_writes(input int target);
        int n;
        n = 0;
        while (writes < target && n < 200) begin
            @(posedge clk); #3; n++;
        end
        if (writes < target) begin
            checks++; failures++;
            $display("FAIL write_timeout: writes %0d, required %0d", writes, target);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        r = mk(3'($urandom_range(0, 5)), 7'($urandom), 3'($urandom), 7'($urandom),
               5'($urandom), 5'($urandom), 5'($urandom), $urandom);
        if ($urandom_range(0, 15) == 0) r.fmt = 3'($urandom_range(6, 7));
        if ($urandom_range(0, 3) != 0) begin
            case (r.fmt)
                3'd1, 3'd2: r.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                3'd3: r.imm = 32'(2 * (int'($urandom_range(0, 4095)) - 2048));
                3'd4: r.imm = $urandom & 32'hFFFF_F000;
                3'd5: r.imm = 32'(2 * (int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)));
                default: r.imm = $urandom;
            endcase
        end
        return r;
    endfunction

    vec_t        vecs[6];
    req_t        rq[3];
    int          w0;
    logic [31:0] c0, a0, d0;
    bit          rnd_done;

    initial begin
        vecs[0] = '{"addi", mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5),
                    32'h0050_0093, BASE};
        vecs[1] = '{"lui",  mk(3'd4, 7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd5, 32'h1234_5000),
                    32'h1234_52B7, BASE + 32'd4};
        vecs[2] = '{"sub",  mk(3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0),
                    32'h4020_81B3, BASE + 32'd8};
        vecs[3] = '{"sw",   mk(3'd2, 7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8),
                    32'h0020_A423, BASE + 32'd12};
        vecs[4] = '{"beq",  mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC),
                    32'hFE20_8EE3, BASE};
        vecs[5] = '{"jal",  mk(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2048),
                    32'h0010_00EF, BASE + 32'd4};

        // Reset values, while reset is held and after release
        idle(2);
        check("rst_ready", 32'(req_ready_out), 32'd1);
        check("rst_we", 32'(mem_we_out), 32'd0);
        check("rst_addr", mem_addr_out, BASE);
        check("rst_data", mem_data_out, 32'd0);
        check("rst_count", inst_count_out, 32'd0);
        check("rst_err", 32'(err_out), 32'd0);
        rst = 1'b1;
        model_reset();
        mon_en = 1;
        idle(1);

        // Directed encodings; fifth write wraps to BASE with DEPTH=4
        mem_ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].r);
            wait_writes(i + 1);
            check({vecs[i].name, "_word"}, last_data, vecs[i].exp_word);
            check({vecs[i].name, "_addr"}, last_addr, vecs[i].exp_addr);
            if (i == 4) check("wrap_count", inst_count_out, 32'd5);
        end
        idle(2);

        // Backpressure: two accepted, third stalls until the first pop
        rq[0] = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd3, 32'd100);
        rq[1] = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd4, 32'hFFFF_FFFF);
        rq[2] = mk(3'd0, 7'h33, 3'd7, 7'h00, 5'd4, 5'd5, 5'd6, 32'd0);
        mem_ready_in = 1'b0;
        w0 = writes;
        send(rq[0]);
        send(rq[1]);
        drive(rq[2]);
        req_valid_in = 1'b1;
        a0 = mem_addr_out;
        d0 = mem_data_out;
        idle(3);
        check("bp_ready_low", 32'(req_ready_out), 32'd0);
        check("bp_we_held", 32'(mem_we_out), 32'd1);
        check("bp_addr_stable", mem_addr_out, a0);
        check("bp_data_stable", mem_data_out, d0);
        mem_ready_in = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after_pop", 32'(req_ready_out), 32'd1);
        @(posedge clk); #1;
        req_valid_in = 1'b0;
        wait_writes(w0 + 3);
        check("bp_last_word", last_data, model_enc(rq[2]));
        idle(2);

        // Flush with a concurrent request: nothing accepted, state cleared
        mem_ready_in = 1'b0;
        send(rq[0]);
        w0 = writes;
        drive(rq[1]);
        req_valid_in = 1'b1;
        flush_in = 1'b1;
        @(posedge clk); #1;
        flush_in = 1'b0;
        req_valid_in = 1'b0;
        check("flush_count", inst_count_out, 32'd0);
        check("flush_we", 32'(mem_we_out), 32'd0);
        check("flush_addr", mem_addr_out, BASE);
        mem_ready_in = 1'b1;
        idle(3);
        check("flush_no_write", 32'(writes), 32'(w0));

        // Misaligned branch offset
        w0 = writes;
        c0 = inst_count_out;
        send(mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'd3));
`ifdef ENC_CHECK_EN
        check("chk_err_pulse", 32'(err_out), 32'd1);
        @(posedge clk); #1;
        check("chk_err_clear", 32'(err_out), 32'd0);
        idle(3);
        check("chk_no_write", 32'(writes), 32'(w0));
        check("chk_count", inst_count_out, c0);
`else
        wait_writes(w0 + 1);
        check("nochk_word", last_data, 32'h0020_8163);
        check("nochk_err", 32'(err_out), 32'd0);
`endif
        idle(2);

        // Asynchronous reset while words are buffered
        mem_ready_in = 1'b0;
        send(rq[0]);
        send(rq[1]);
        w0 = writes;
        rst = 1'b0;
        model_reset();
        #2;
        check("arst_we", 32'(mem_we_out), 32'd0);
        check("arst_count", inst_count_out, 32'd0);
        check("arst_addr", mem_addr_out, BASE);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_ready_in = 1'b1;
        idle(3);
        check("arst_no_write", 32'(writes), 32'(w0));

        // Randomized traffic with random memory backpressure
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(rand_req());
                    if ($urandom_range(0, 7) == 0) idle(1);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    mem_ready_in = ($urandom_range(0, 3) != 0);
                end
            end
        join
        mem_ready_in = 1'b1;
        idle(4);
        check("drain_we", 32'(mem_we_out), 32'd0);

        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
